alu_reg_pipeline: RTL
=====================

Name: alu_reg_pipeline

Overview:
- Pipeline that feeds the combinational ALU and retires its results: accepts issued reg-reg/reg-imm integer ops, collects operands (values or pending physical-register tags resolved by the forward bus), drives op/A/B into the ALU, registers the result and presents it to the writeback arbiter.
- Sits between the integer issue queue and the writeback bus.
- Throughput 1 op/cycle with valid/ready backpressure at both ends.

Parameters:
- LOG_PR_COUNT, 7, width of physical register tags.
- LOG_ROB_ENTRIES, 7, width of ROB index.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- issue_valid  input  1  issue request
- issue_ready  output  1  pipeline accepts issue this cycle
- issue_op  input  4  ALU op encoding, passed unchanged to alu
- issue_A_pending  input  1  A not yet available; wait on issue_A_PR
- issue_A_PR  input  LOG_PR_COUNT  tag for A
- issue_A_data  input  32  A value when not pending
- issue_B_pending  input  1  B not yet available
- issue_B_PR  input  LOG_PR_COUNT  tag for B
- issue_B_data  input  32  B value or immediate when not pending
- issue_dest_PR  input  LOG_PR_COUNT  destination tag
- issue_ROB_index  input  LOG_ROB_ENTRIES  ROB index
- fwd_valid  input  1  forward bus broadcast
- fwd_PR  input  LOG_PR_COUNT  broadcast tag
- fwd_data  input  32  broadcast value
- WB_valid  output  1  result available
- WB_ready  input  1  arbiter accepts result
- WB_data  output  32  ALU result
- WB_PR  output  LOG_PR_COUNT  destination tag
- WB_ROB_index  output  LOG_ROB_ENTRIES  ROB index

Behaviour:
- Two register stages: OC (operand collect) and WB. The alu sub-module sits combinationally between them.
- Reset (RST high at a rising edge): OC_valid=0, WB_valid=0, all OC/WB payload registers and WB_data/WB_PR/WB_ROB_index = 0. issue_ready = 1 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight ops. Nothing is retired.
- OC_ready_ops = OC_valid and !A_pending and !B_pending.
- WB_free = !WB_valid or WB_ready.
- OC_fire = OC_ready_ops and WB_free.
- issue_ready = !OC_valid or OC_fire. This is combinational; a single bubble is never required.
- Issue accept (issue_valid and issue_ready): OC loads op, tags, values and pending flags.
- Forward capture at issue: if an operand is pending and fwd_valid with fwd_PR equal to its tag in the same cycle, OC loads fwd_data and clears that pending flag. A broadcast is never lost at the issue boundary.
- Forward capture while held: each cycle, a pending OC operand matching a valid forward latches fwd_data and clears its flag. The operand is usable from the next cycle, so there is no same-cycle forward-to-ALU path.
- Both operands matching the same broadcast both capture it.
- OC_fire: WB loads the alu output (op/A/B from OC), dest_PR and ROB_index, and WB_valid=1.
- No OC_fire while WB_valid and WB_ready: WB_valid=0.
- WB stall (WB_valid and !WB_ready): WB payload holds stable. OC holds, but still captures forwards.
- Latency with operands ready at issue: accept at edge N, WB_valid from edge N+1 to N+2, i.e. 2 cycles issue-to-WB.
- Back-to-back ops sustain 1/cycle while WB_ready=1.
- WB_valid is never dropped without WB_ready (no retraction).
- ALU semantics, shift masking and signedness are owned by alu. This block performs no arithmetic.

Decomposition:
- Shared core types package: LOG_PR_COUNT, LOG_ROB_ENTRIES defaults, and the ALU op encoding constants (ADD=0000, SUB=1000, SLL=?001, SLT=?010, SLTU=?011, XOR=?100, SRL=0101, SRA=1101, OR=?110, AND=?111).
- One sub-module: alu instantiated unchanged. All pipeline and handshake logic stays in alu_reg_pipeline.

Test Plan:
- Reset then issue ADD, A=5, B=7, no pending, WB_ready=1: issue_ready=1, and two cycles later WB_valid=1, WB_data=12, tag/ROB echoed. WB_valid=0 the next cycle.
- Issue SUB with A pending on PR 9, B=3; fwd PR 9 = 10 three cycles later: WB_data=7 appears 2 cycles after the forward. No WB before it.
- Issue SRA with A pending on PR 4 while fwd_valid PR 4 = 0x8000_0000 in the same cycle, B=4: WB_data=0xF800_0000 two cycles later.
- Four back-to-back ADDs with WB_ready=0 for cycles 2–5: WB holds the first result stable, issue_ready drops after the second op. After release all four retire in order, one per cycle, with no loss or duplication.
- Both A and B pending on PR 12; one broadcast PR 12 = 0xFFFF_FFFF; op SLTU: WB_data=0.
- Assert RST while OC and WB are both valid: next cycle WB_valid=0, issue_ready=1, and no stale result appears afterward.

Source files
------------

// File: rtl/alu_reg_pipeline_pkg.sv
// Shared core types for the integer ALU pipeline: tag widths and the ALU op encoding.
// Bit 3 of the op selects SUB/SRA; the low three bits pick the function.
package alu_reg_pipeline_pkg;

    localparam int DEFAULT_LOG_PR_COUNT    = 7;
    localparam int DEFAULT_LOG_ROB_ENTRIES = 7;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SLL  = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SR   = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } alu_f3_e;

    function automatic alu_f3_e op_f3(input logic [3:0] op);
        return alu_f3_e'(op[2:0]);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; owns shift masking and signedness.
module alu
    import alu_reg_pipeline_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = 32'd0;
        unique case (op_f3(op))
            F3_ADD:  result = op[3] ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            F3_SLTU: result = {31'd0, a < b};
            F3_XOR:  result = a ^ b;
            F3_SR:   result = op[3] ? 32'($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_reg_pipeline.sv
// Two-stage ALU pipeline: operand collect (with forward-bus capture) feeding the
// ALU, then a result register presented to the writeback arbiter.
module alu_reg_pipeline
    import alu_reg_pipeline_pkg::*;
#(
    parameter int LOG_PR_COUNT    = DEFAULT_LOG_PR_COUNT,
    parameter int LOG_ROB_ENTRIES = DEFAULT_LOG_ROB_ENTRIES
)
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [3:0]                 issue_op,
    input  logic                       issue_A_pending,
    input  logic [LOG_PR_COUNT-1:0]    issue_A_PR,
    input  logic [31:0]                issue_A_data,
    input  logic                       issue_B_pending,
    input  logic [LOG_PR_COUNT-1:0]    issue_B_PR,
    input  logic [31:0]                issue_B_data,
    input  logic [LOG_PR_COUNT-1:0]    issue_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0] issue_ROB_index,
    input  logic                       fwd_valid,
    input  logic [LOG_PR_COUNT-1:0]    fwd_PR,
    input  logic [31:0]                fwd_data,
    output logic                       WB_valid,
    input  logic                       WB_ready,
    output logic [31:0]                WB_data,
    output logic [LOG_PR_COUNT-1:0]    WB_PR,
    output logic [LOG_ROB_ENTRIES-1:0] WB_ROB_index
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a raised valid and its payload stay put until that transfer.
    logic                       oc_valid_q, oc_valid_d;
    logic [3:0]                 oc_op_q, oc_op_d;
    logic                       oc_a_pend_q, oc_a_pend_d;
    logic [LOG_PR_COUNT-1:0]    oc_a_pr_q, oc_a_pr_d;
    logic [31:0]                oc_a_data_q, oc_a_data_d;
    logic                       oc_b_pend_q, oc_b_pend_d;
    logic [LOG_PR_COUNT-1:0]    oc_b_pr_q, oc_b_pr_d;
    logic [31:0]                oc_b_data_q, oc_b_data_d;
    logic [LOG_PR_COUNT-1:0]    oc_dest_q, oc_dest_d;
    logic [LOG_ROB_ENTRIES-1:0] oc_rob_q, oc_rob_d;

    logic                       wb_valid_q, wb_valid_d;
    logic [31:0]                wb_data_q, wb_data_d;
    logic [LOG_PR_COUNT-1:0]    wb_pr_q, wb_pr_d;
    logic [LOG_ROB_ENTRIES-1:0] wb_rob_q, wb_rob_d;

    logic        oc_ready_ops, wb_free, oc_fire, issue_fire;
    logic        a_hit_in, b_hit_in;
    logic [31:0] alu_result;

    assign oc_ready_ops = oc_valid_q && !oc_a_pend_q && !oc_b_pend_q;
    assign wb_free      = !wb_valid_q || WB_ready;
    assign oc_fire      = oc_ready_ops && wb_free;
    assign issue_ready  = !oc_valid_q || oc_fire;
    assign issue_fire   = issue_valid && issue_ready;

    assign a_hit_in = issue_A_pending && fwd_valid && (fwd_PR == issue_A_PR);
    assign b_hit_in = issue_B_pending && fwd_valid && (fwd_PR == issue_B_PR);

    alu u_alu (
        .op     (oc_op_q),
        .a      (oc_a_data_q),
        .b      (oc_b_data_q),
        .result (alu_result)
    );

    always_comb begin
        oc_valid_d  = oc_valid_q;
        oc_op_d     = oc_op_q;
        oc_a_pend_d = oc_a_pend_q;
        oc_a_pr_d   = oc_a_pr_q;
        oc_a_data_d = oc_a_data_q;
        oc_b_pend_d = oc_b_pend_q;
        oc_b_pr_d   = oc_b_pr_q;
        oc_b_data_d = oc_b_data_q;
        oc_dest_d   = oc_dest_q;
        oc_rob_d    = oc_rob_q;

        // Held operands snoop the forward bus every cycle, including during a WB stall.
        if (oc_a_pend_q && fwd_valid && (fwd_PR == oc_a_pr_q)) begin
            oc_a_pend_d = 1'b0;
            oc_a_data_d = fwd_data;
        end
        if (oc_b_pend_q && fwd_valid && (fwd_PR == oc_b_pr_q)) begin
            oc_b_pend_d = 1'b0;
            oc_b_data_d = fwd_data;
        end

        if (issue_fire) begin
            oc_valid_d  = 1'b1;
            oc_op_d     = issue_op;
            oc_a_pend_d = issue_A_pending && !a_hit_in;
            oc_a_pr_d   = issue_A_PR;
            oc_a_data_d = a_hit_in ? fwd_data : issue_A_data;
            oc_b_pend_d = issue_B_pending && !b_hit_in;
            oc_b_pr_d   = issue_B_PR;
            oc_b_data_d = b_hit_in ? fwd_data : issue_B_data;
            oc_dest_d   = issue_dest_PR;
            oc_rob_d    = issue_ROB_index;
        end else if (oc_fire) begin
            oc_valid_d = 1'b0;
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_pr_d    = wb_pr_q;
        wb_rob_d   = wb_rob_q;
        if (oc_fire) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
            wb_pr_d    = oc_dest_q;
            wb_rob_d   = oc_rob_q;
        end else if (WB_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            oc_valid_q  <= 1'b0;
            oc_op_q     <= '0;
            oc_a_pend_q <= 1'b0;
            oc_a_pr_q   <= '0;
            oc_a_data_q <= '0;
            oc_b_pend_q <= 1'b0;
            oc_b_pr_q   <= '0;
            oc_b_data_q <= '0;
            oc_dest_q   <= '0;
            oc_rob_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_pr_q     <= '0;
            wb_rob_q    <= '0;
        end else begin
            oc_valid_q  <= oc_valid_d;
            oc_op_q     <= oc_op_d;
            oc_a_pend_q <= oc_a_pend_d;
            oc_a_pr_q   <= oc_a_pr_d;
            oc_a_data_q <= oc_a_data_d;
            oc_b_pend_q <= oc_b_pend_d;
            oc_b_pr_q   <= oc_b_pr_d;
            oc_b_data_q <= oc_b_data_d;
            oc_dest_q   <= oc_dest_d;
            oc_rob_q    <= oc_rob_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_pr_q     <= wb_pr_d;
            wb_rob_q    <= wb_rob_d;
        end
    end

    assign WB_valid     = wb_valid_q;
    assign WB_data      = wb_data_q;
    assign WB_PR        = wb_pr_q;
    assign WB_ROB_index = wb_rob_q;

endmodule
